// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and launch sequencer feeding uart_send
// Optional inter-frame gap state: UART_TX_FEEDER_GAP_EN
module uart_tx_feeder #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int BUSY_TMO   = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tmo_err,
    input  logic              send_busy,
    output logic              send_trig,
    output logic [7:0]        send_data
);

    localparam int TMR_MAX = (BUSY_TMO > GAP_CYCLES) ? BUSY_TMO : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_BUSY,
        S_WAIT_DONE
`ifdef UART_TX_FEEDER_GAP_EN
        , S_GAP
`endif
    } state_t;

    logic [7:0]        mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              tmo_err_q, tmo_err_d;
    logic              send_trig_q, send_trig_d;
    logic [7:0]        send_data_q, send_data_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              wr_accept;
    logic              pop;

    // Pop only when uart_send is idle, so a reset mid-frame never re-triggers it.
    assign wr_accept = wr_en && !full_q;
    assign pop       = (state_q == S_IDLE) && !empty_q && !send_busy;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        send_data_d = send_data_q;
        send_trig_d = 1'b0;
        tmo_err_d   = tmo_err_q;
        overflow_d  = overflow_q | (wr_en & full_q);
        wr_ptr_d    = wr_ptr_q + ADDR_W'(wr_accept);
        rd_ptr_d    = rd_ptr_q + ADDR_W'(pop);
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (ADDR_W + 1)'(DEPTH));
        empty_d = (count_d == '0);

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    send_data_d = mem_q[rd_ptr_q];
                    state_d     = S_TRIG;
                end
            end
            S_TRIG: begin
                send_trig_d = 1'b1;
                tmr_d       = '0;
                state_d     = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (send_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_q == TMR_W'(BUSY_TMO - 1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!send_busy) begin
`ifdef UART_TX_FEEDER_GAP_EN
                    tmr_d   = '0;
                    state_d = S_GAP;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef UART_TX_FEEDER_GAP_EN
            S_GAP: begin
                if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
            send_trig_q <= 1'b0;
            send_data_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            tmo_err_q   <= tmo_err_d;
            send_trig_q <= send_trig_d;
            send_data_q <= send_data_d;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign tmo_err   = tmo_err_q;
    assign send_trig = send_trig_q;
    assign send_data = send_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench: uart_send model, tx decoder, queue reference
module tb_uart_tx_feeder;

    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 4;
    localparam int BUSY_TMO = 4;
    localparam int GAP_CYC  = 2;
    // Idle-high cycles between stop bit and next start bit with this uart_send model:
    // WAIT_DONE sees busy low, IDLE pops, TRIG, uart samples trig.
    localparam int BASE_GAP = 4;
`ifdef UART_TX_FEEDER_GAP_EN
    localparam int EXP_GAP = BASE_GAP + GAP_CYC;
`else
    localparam int EXP_GAP = BASE_GAP;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              full, empty, overflow, tmo_err, send_trig, send_busy;
    logic [ADDR_W:0]   count;
    logic [7:0]        send_data;
    logic              force_hi = 1'b0;
    logic              tie_low = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TMO(BUSY_TMO), .GAP_CYCLES(GAP_CYC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .tmo_err(tmo_err),
        .send_busy(send_busy), .send_trig(send_trig), .send_data(send_data)
    );

    always #5 clk = ~clk;

    // Behavioural uart_send: start, 8 data bits LSB first, stop; busy drops after the stop bit.
    logic       u_busy = 1'b0;
    logic       u_tx = 1'b1;
    logic [9:0] u_frame = 10'h3FF;
    int         u_idx = 0;
    wire        uart_trig = send_trig & ~tie_low;
    assign send_busy = force_hi ? 1'b1 : (tie_low ? 1'b0 : u_busy);

    always @(posedge clk) begin
        if (!u_busy) begin
            if (uart_trig === 1'b1) begin
                u_frame <= {1'b1, send_data, 1'b0};
                u_tx    <= 1'b0;
                u_busy  <= 1'b1;
                u_idx   <= 1;
            end
        end else if (u_idx < 10) begin
            u_tx  <= u_frame[u_idx];
            u_idx <= u_idx + 1;
        end else begin
            u_busy <= 1'b0;
        end
    end

    logic [7:0] rx_q [$];
    int         rx_total = 0;
    int         last_gap = -1;
    int         stop_errs = 0;
    int         trig_cnt = 0;
    int         wide_trig = 0;
    logic       trig_prev = 1'b0;

    always @(negedge clk) begin
        if (send_trig === 1'b1) trig_cnt++;
        if (send_trig === 1'b1 && trig_prev) wide_trig++;
        trig_prev <= (send_trig === 1'b1);
    end

    initial begin : decoder
        int dcyc;
        int last_stop;
        int st;
        logic [7:0] b;
        dcyc = 0;
        last_stop = -1;
        forever begin
            @(negedge clk);
            dcyc++;
            if (u_tx == 1'b0) begin
                st = dcyc;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    dcyc++;
                    b[i] = u_tx;
                end
                @(negedge clk);
                dcyc++;
                if (u_tx !== 1'b1) stop_errs++;
                if (last_stop >= 0) last_gap = st - last_stop - 1;
                last_stop = dcyc;
                rx_q.push_back(b);
                rx_total++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, (rx_q.size() >= n), 1);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        check(tag, got, exp);
    endtask

    task automatic settle();
        int k = 0;
        while ((u_busy || !empty) && k < 400) begin
            tick();
            k++;
        end
        repeat (12) tick();
    endtask

    initial begin : stim
        logic [7:0] model_q [$];
        logic       exp_ovf;
        int         t0;
        int         n;
        int         sent;
        logic [7:0] b;

        repeat (3) tick();
        do_reset();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_trig", send_trig, 0);
        check("rst_data", send_data, 8'h00);
        check("rst_ovf", overflow, 0);
        check("rst_tmo", tmo_err, 0);

        // 1: single byte, launch latency and frame contents
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("t1_count_e0", count, 1);
        tick();
        check("t1_data_e1", send_data, 8'hA5);
        check("t1_trig_e1", send_trig, 0);
        tick();
        check("t1_trig_e2", send_trig, 1);
        tick();
        check("t1_trig_e3", send_trig, 0);
        wait_rx("t1_wait", 1, 60);
        expect_rx("t1_byte", 8'hA5);
        settle();
        check("t1_empty", empty, 1);
        check("t1_tmo", tmo_err, 0);

        // 2: fill to full, overflow on the 17th, drain in order
        force_hi = 1'b1;
        exp_ovf = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            write_byte(8'(i));
            if (model_q.size() < DEPTH) model_q.push_back(8'(i));
            else exp_ovf = 1'b1;
        end
        check("t2_count", count, model_q.size());
        check("t2_full", full, 1);
        check("t2_ovf", overflow, exp_ovf);
        force_hi = 1'b0;
        wait_rx("t2_wait", DEPTH, DEPTH * 30);
        while (model_q.size() > 0) expect_rx("t2_byte", model_q.pop_front());
        settle();
        check("t2_extra", rx_q.size(), 0);
        check("t2_ovf_sticky", overflow, 1);

        // 3: busy held high blocks launch
        force_hi = 1'b1;
        t0 = trig_cnt;
        write_byte(8'h3C);
        repeat (20) tick();
        check("t3_no_trig", trig_cnt - t0, 0);
        check("t3_count", count, 1);
        force_hi = 1'b0;
        wait_rx("t3_wait", 1, 60);
        expect_rx("t3_byte", 8'h3C);
        settle();
        check("t3_one_trig", trig_cnt - t0, 1);

        // 4: busy never rises -> timeout, then normal launch
        do_reset();
        tie_low = 1'b1;
        t0 = trig_cnt;
        write_byte(8'h77);
        n = 0;
        while (send_trig !== 1'b1 && n < 10) begin tick(); n++; end
        check("t4_trig", send_trig, 1);
        n = 0;
        while (tmo_err !== 1'b1 && n < 20) begin tick(); n++; end
        check("t4_tmo_lat", n, BUSY_TMO);
        check("t4_one_trig", trig_cnt - t0, 1);
        tie_low = 1'b0;
        write_byte(8'h78);
        wait_rx("t4_wait", 1, 60);
        expect_rx("t4_byte", 8'h78);
        settle();
        check("t4_tmo_sticky", tmo_err, 1);

        // 5: reset during the second frame
        do_reset();
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        wait_rx("t5_wait1", 1, 60);
        n = 0;
        while (!u_busy && n < 20) begin tick(); n++; end
        repeat (3) tick();
        do_reset();
        check("t5_count", count, 0);
        check("t5_empty", empty, 1);
        t0 = trig_cnt;
        repeat (60) tick();
        check("t5_no_trig", trig_cnt - t0, 0);
        check("t5_frames", rx_q.size(), 2);
        expect_rx("t5_byte0", 8'h11);
        expect_rx("t5_byte1", 8'h22);

        // 6: inter-frame gap
        force_hi = 1'b1;
        write_byte(8'h5A);
        write_byte(8'hC3);
        force_hi = 1'b0;
        wait_rx("t6_wait", 2, 80);
        expect_rx("t6_byte0", 8'h5A);
        expect_rx("t6_byte1", 8'hC3);
        check("t6_gap", last_gap, EXP_GAP);
        settle();

        // Random traffic against a plain in-order queue
        do_reset();
        sent = rx_total;
        for (int i = 0; i < 60; i++) begin
            n = 0;
            while ((sent - rx_total) >= DEPTH - 1 && n < 2000) begin tick(); n++; end
            b = 8'($urandom);
            write_byte(b);
            model_q.push_back(b);
            sent++;
            repeat ($urandom_range(0, 15)) tick();
        end
        wait_rx("rnd_wait", model_q.size(), 4000);
        while (model_q.size() > 0) expect_rx("rnd_byte", model_q.pop_front());
        settle();
        check("rnd_ovf", overflow, 0);
        check("rnd_tmo", tmo_err, 0);
        check("stop_bits", stop_errs, 0);
        check("trig_width", wide_trig, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
